pixel_frame_writer: RTL and testbench
=====================================

// Module: pixel_frame_writer
// PURPOSE
//  Sits directly downstream of the Ethernet image/audio splitter and consumes its addr/pixel strobes.
//  Turns each packet's 24-bit start pixel index plus its PIXELS_PER_PKT pixel bytes into frame-buffer write beats.
//  Beats go through a small FIFO to a BRAM port that can stall (wr_ready).
//  Range-checks packets, detects short packets and flags frame completion.
// PARAMETERS
//  PIXELS_PER_PKT  320    pixel bytes per packet
//  FRAME_PIXELS    76800  pixels per frame (320x240); legal indices 0..FRAME_PIXELS-1
//  ADDR_W          17     frame-buffer write address width
//  FIFO_DEPTH      4      write-beat FIFO entries (power of 2)
// PORTS
//  clk            in   1       system clock
//  rst_n          in   1       synchronous reset, active-low
//  addr_axiov     in   1       1-cycle strobe: addr holds packet start pixel index
//  addr           in   24      packet start pixel index
//  pixel_axiov    in   1       1-cycle strobe: pixel holds next pixel byte
//  pixel          in   8       pixel byte
//  wr_ready       in   1       frame-buffer port accepts beat this cycle
//  wr_valid       out  1       beat available (FIFO non-empty)
//  wr_addr        out  ADDR_W  frame-buffer address of beat
//  wr_data        out  8       pixel byte of beat
//  pkt_done       out  1       1-cycle pulse: full packet of pixels accepted
//  frame_done     out  1       1-cycle pulse: completed packet ended at FRAME_PIXELS
//  bad_addr_err   out  1       1-cycle pulse: packet rejected (out of range)
//  short_pkt_err  out  1       1-cycle pulse: new addr arrived before packet complete
//  ovf_count      out  16      saturating count of beats dropped on FIFO full
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE, pix_cnt=0, base=0, FIFO emptied.
//   All outputs 0, including wr_valid, pulses and ovf_count. Applies mid-packet; in-flight beats are discarded.
//  States:
//   IDLE: waits for addr_axiov.
//   ACTIVE: accepts pixels.
//   DROP: discards pixels until the next addr_axiov.
//  addr_axiov, any state:
//   if addr + PIXELS_PER_PKT <= FRAME_PIXELS (25-bit compare): base<=addr[ADDR_W-1:0], pix_cnt<=0, go ACTIVE.
//   otherwise: pulse bad_addr_err, go DROP.
//   if state was ACTIVE: additionally pulse short_pkt_err (same cycle).
//  pixel_axiov in ACTIVE:
//   push {base+pix_cnt, pixel}; pix_cnt++.
//   when pix_cnt reaches PIXELS_PER_PKT (this push is the last), next state IDLE and pkt_done pulses the following cycle.
//   frame_done pulses with pkt_done if base+PIXELS_PER_PKT == FRAME_PIXELS.
//  pixel_axiov in IDLE/DROP: ignored; no push, no count.
//  addr_axiov and pixel_axiov in the same cycle: addr handled, pixel ignored.
//  FIFO push while full and no pop:
//   beat dropped, ovf_count++ (holds at 16'hFFFF), pix_cnt still advances so later addresses stay aligned.
//  FIFO push while full with pop (wr_valid&&wr_ready) in the same cycle: push accepted.
//  Output handshake:
//   wr_valid/wr_addr/wr_data show the FIFO head; pop on wr_valid&&wr_ready.
//   While wr_valid=1 and wr_ready=0, wr_addr/wr_data are held stable.
//  Latency: pixel_axiov at cycle N into an empty FIFO -> wr_valid=1 at N+1.
//  Ordering: beats leave in arrival order; the FIFO never reorders or duplicates.
//  All pulses are registered: asserted the cycle after the causing input edge.
// STRUCTURE
//  lightboard_pkg:
//   PIXELS_PER_PKT, FRAME_W=320, FRAME_H=240, FRAME_PIXELS.
//   wr_state_t enum {IDLE, ACTIVE, DROP}.
//   typedef struct {addr; data} wr_beat_t.
//  Sub-module pixel_wr_fifo: sync FIFO of wr_beat_t, depth FIFO_DEPTH, full/empty, push-when-full-with-pop.
//  Top holds FSM, pix_cnt, base, address adder, error pulses, ovf_count.
// TESTING
//  1 addr=0, 320 pixels 0..255,0..63, wr_ready=1
//     -> 320 beats, wr_addr 0..319, data matches; pkt_done once; no errors.
//  2 addr=76480, 320 pixels -> last beat wr_addr=76799; pkt_done and frame_done same cycle.
//  3 addr=76481 then 320 pixels -> bad_addr_err once; zero beats; next addr=0 packet writes normally.
//  4 addr=640, 100 pixels, then addr=960, 320 pixels
//     -> short_pkt_err once; beats 640..739 then 960..1279; one pkt_done.
//  5 addr=0, 320 pixels, wr_ready=0 throughout
//     -> 4 beats held (addr 0..3); ovf_count=316; after wr_ready=1 exactly 4 beats drain.
//  6 rst_n=0 for 1 cycle after 50 pixels
//     -> wr_valid=0 and ovf_count=0 next cycle; following pixels ignored until a new addr_axiov.

Source files
------------

// File: rtl/lightboard_pkg.sv
// Shared constants and types for the frame-buffer write path.
//   PIXELS_PER_PKT : pixel bytes carried by one packet
//   FRAME_W/H      : frame geometry, FRAME_PIXELS = FRAME_W * FRAME_H
//   BEAT_ADDR_W    : frame-buffer address width carried in a write beat
//   wr_state_t     : packet-tracking FSM states
//   wr_beat_t      : one frame-buffer write (address + pixel byte)
package lightboard_pkg;

    localparam int unsigned PIXELS_PER_PKT = 320;
    localparam int unsigned FRAME_W        = 320;
    localparam int unsigned FRAME_H        = 240;
    localparam int unsigned FRAME_PIXELS   = FRAME_W * FRAME_H;
    localparam int unsigned BEAT_ADDR_W    = 17;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DROP
    } wr_state_t;

    typedef struct packed {
        logic [BEAT_ADDR_W-1:0] addr;
        logic [7:0]             data;
    } wr_beat_t;

endpackage

// File: rtl/pixel_wr_fifo.sv
// Synchronous FIFO of write beats.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push       : request to store push_beat
//   push_beat  : beat to store
//   pop        : consumer takes the head beat this cycle
//   full/empty : occupancy flags
//   head       : oldest stored beat (meaningful only when !empty)
// A push while full is accepted when a pop happens in the same cycle.
module pixel_wr_fifo
    import lightboard_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  wr_beat_t push_beat,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output wr_beat_t head
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    wr_beat_t         mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_beat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_frame_writer.sv
// Converts packet start indices and pixel bytes into frame-buffer write beats.
//   clk, rst_n     : clock, synchronous active-low reset
//   addr_axiov     : strobe, addr holds a packet start pixel index
//   addr           : packet start pixel index (24 bit)
//   pixel_axiov    : strobe, pixel holds the next pixel byte
//   pixel          : pixel byte
//   wr_ready       : frame-buffer port accepts a beat this cycle
//   wr_valid       : beat available
//   wr_addr        : frame-buffer address of the head beat
//   wr_data        : pixel byte of the head beat
//   pkt_done       : pulse, a full packet of pixels was accepted
//   frame_done     : pulse, the completed packet ended at the frame end
//   bad_addr_err   : pulse, packet rejected as out of range
//   short_pkt_err  : pulse, new addr arrived before the packet completed
//   ovf_count      : saturating count of beats dropped on FIFO full
module pixel_frame_writer #(
    parameter int unsigned PIXELS_PER_PKT = lightboard_pkg::PIXELS_PER_PKT,
    parameter int unsigned FRAME_PIXELS   = lightboard_pkg::FRAME_PIXELS,
    parameter int unsigned ADDR_W         = lightboard_pkg::BEAT_ADDR_W,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              addr_axiov,
    input  logic [23:0]       addr,
    input  logic              pixel_axiov,
    input  logic [7:0]        pixel,
    input  logic              wr_ready,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              pkt_done,
    output logic              frame_done,
    output logic              bad_addr_err,
    output logic              short_pkt_err,
    output logic [15:0]       ovf_count
);

    import lightboard_pkg::*;

    localparam int unsigned CNT_W = $clog2(PIXELS_PER_PKT + 1);

    wr_state_t         state;
    wr_state_t         next_state;
    logic [CNT_W-1:0]  pix_cnt;
    logic [ADDR_W-1:0] base;
    logic [24:0]       addr_end;
    logic [24:0]       base_end;
    logic              in_range;
    logic              push;
    logic              last_pix;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    wr_beat_t          push_beat;
    wr_beat_t          head;

    // 25-bit sums so a start index near 2^24 cannot wrap into range.
    assign addr_end = {1'b0, addr} + 25'(PIXELS_PER_PKT);
    assign base_end = 25'(base) + 25'(PIXELS_PER_PKT);
    assign in_range = (addr_end <= 25'(FRAME_PIXELS));

    assign push_beat.addr = BEAT_ADDR_W'(base + ADDR_W'(pix_cnt));
    assign push_beat.data = pixel;

    assign wr_valid = !fifo_empty;
    assign pop      = wr_valid && wr_ready;
    assign wr_addr  = wr_valid ? ADDR_W'(head.addr) : '0;
    assign wr_data  = wr_valid ? head.data : '0;

    always_comb begin
        next_state = state;
        push       = 1'b0;
        last_pix   = 1'b0;
        if (addr_axiov) begin
            next_state = in_range ? ACTIVE : DROP;
        end else if (pixel_axiov && state == ACTIVE) begin
            push = 1'b1;
            if (pix_cnt == CNT_W'(PIXELS_PER_PKT - 1)) begin
                last_pix   = 1'b1;
                next_state = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            pix_cnt       <= '0;
            base          <= '0;
            pkt_done      <= 1'b0;
            frame_done    <= 1'b0;
            bad_addr_err  <= 1'b0;
            short_pkt_err <= 1'b0;
            ovf_count     <= '0;
        end else begin
            state         <= next_state;
            pkt_done      <= last_pix;
            frame_done    <= last_pix && (base_end == 25'(FRAME_PIXELS));
            bad_addr_err  <= addr_axiov && !in_range;
            short_pkt_err <= addr_axiov && (state == ACTIVE);
            if (addr_axiov && in_range) begin
                base    <= addr[ADDR_W-1:0];
                pix_cnt <= '0;
            end else if (push) begin
                // Advances even when the beat is dropped, keeping later addresses aligned.
                pix_cnt <= pix_cnt + 1'b1;
            end
            if (push && fifo_full && !pop && ovf_count != '1) begin
                ovf_count <= ovf_count + 1'b1;
            end
        end
    end

    pixel_wr_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_beat (push_beat),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

endmodule

// File: tb/tb_pixel_frame_writer.sv
module tb_pixel_frame_writer;

    logic        clk;
    logic        rst_n;
    logic        addr_axiov;
    logic [23:0] addr;
    logic        pixel_axiov;
    logic [7:0]  pixel;
    logic        wr_ready;
    logic        wr_valid;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    logic        pkt_done;
    logic        frame_done;
    logic        bad_addr_err;
    logic        short_pkt_err;
    logic [15:0] ovf_count;

    int vectors;
    int miscompares;

    // Beats and pulses observed since the last clear_log.
    int   q_addr [$];
    int   q_data [$];
    int   n_pkt;
    int   n_frame;
    int   n_bad;
    int   n_short;
    int   n_both;

    pixel_frame_writer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr_axiov    (addr_axiov),
        .addr          (addr),
        .pixel_axiov   (pixel_axiov),
        .pixel         (pixel),
        .wr_ready      (wr_ready),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .pkt_done      (pkt_done),
        .frame_done    (frame_done),
        .bad_addr_err  (bad_addr_err),
        .short_pkt_err (short_pkt_err),
        .ovf_count     (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_valid && wr_ready) begin
                q_addr.push_back(int'(wr_addr));
                q_data.push_back(int'(wr_data));
            end
            if (pkt_done)                n_pkt++;
            if (frame_done)              n_frame++;
            if (bad_addr_err)            n_bad++;
            if (short_pkt_err)           n_short++;
            if (pkt_done && frame_done)  n_both++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        n_pkt = 0; n_frame = 0; n_bad = 0; n_short = 0; n_both = 0;
    endtask

    task automatic send_addr(input int a);
        addr_axiov = 1'b1;
        addr       = 24'(a);
        tick();
        addr_axiov = 1'b0;
    endtask

    task automatic send_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            pixel_axiov = 1'b1;
            pixel       = 8'(i);
            tick();
        end
        pixel_axiov = 1'b0;
    endtask

    task automatic drain();
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        vectors++;
        if ({wr_valid, pkt_done, frame_done, bad_addr_err, short_pkt_err} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {wr_valid, pkt_done, frame_done, bad_addr_err, short_pkt_err});
        end
        vectors++;
        if (ovf_count !== 16'd0 || wr_addr !== 17'd0 || wr_data !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_data: got ovf=%0d addr=%0d data=%0d expected 0/0/0",
                     ovf_count, wr_addr, wr_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_packet();
        clear_log();
        wr_ready = 1'b1;
        send_addr(0);
        send_pixels(320);
        drain();
        vectors++;
        if (q_addr.size() !== 320) begin
            miscompares++;
            $display("FAIL basic_count: got %0d expected 320", q_addr.size());
        end else begin
            for (int i = 0; i < 320; i++) begin
                vectors++;
                if (q_addr[i] !== i || q_data[i] !== (i % 256)) begin
                    miscompares++;
                    $display("FAIL basic_beat[%0d]: got %0d/%0d expected %0d/%0d",
                             i, q_addr[i], q_data[i], i, i % 256);
                end
            end
        end
        vectors++;
        if (n_pkt !== 1 || n_frame !== 0 || n_bad !== 0 || n_short !== 0 || ovf_count !== 16'd0) begin
            miscompares++;
            $display("FAIL basic_pulses: got pkt=%0d frame=%0d bad=%0d short=%0d ovf=%0d expected 1/0/0/0/0",
                     n_pkt, n_frame, n_bad, n_short, ovf_count);
        end
    endtask

    task automatic test_frame_end();
        clear_log();
        send_addr(76480);
        send_pixels(320);
        drain();
        vectors++;
        if (q_addr.size() !== 320) begin
            miscompares++;
            $display("FAIL frame_count: got %0d expected 320", q_addr.size());
        end else begin
            vectors++;
            if (q_addr[0] !== 76480 || q_addr[319] !== 76799 || q_data[319] !== 63) begin
                miscompares++;
                $display("FAIL frame_ends: got first=%0d last=%0d/%0d expected 76480 76799/63",
                         q_addr[0], q_addr[319], q_data[319]);
            end
        end
        vectors++;
        if (n_pkt !== 1 || n_frame !== 1 || n_both !== 1) begin
            miscompares++;
            $display("FAIL frame_pulses: got pkt=%0d frame=%0d same_cycle=%0d expected 1/1/1",
                     n_pkt, n_frame, n_both);
        end
    endtask

    task automatic test_bad_addr();
        clear_log();
        send_addr(76481);
        send_pixels(320);
        drain();
        vectors++;
        if (n_bad !== 1 || q_addr.size() !== 0 || n_pkt !== 0 || n_short !== 0) begin
            miscompares++;
            $display("FAIL bad_reject: got bad=%0d beats=%0d pkt=%0d short=%0d expected 1/0/0/0",
                     n_bad, q_addr.size(), n_pkt, n_short);
        end
        clear_log();
        send_addr(0);
        send_pixels(320);
        drain();
        vectors++;
        if (q_addr.size() !== 320 || n_pkt !== 1 || n_bad !== 0) begin
            miscompares++;
            $display("FAIL bad_recover: got beats=%0d pkt=%0d bad=%0d expected 320/1/0",
                     q_addr.size(), n_pkt, n_bad);
        end else begin
            vectors++;
            if (q_addr[0] !== 0 || q_addr[319] !== 319 || q_data[300] !== 44) begin
                miscompares++;
                $display("FAIL bad_recover_beats: got %0d %0d %0d expected 0 319 44",
                         q_addr[0], q_addr[319], q_data[300]);
            end
        end
    endtask

    task automatic test_short_packet();
        int ea;
        int ed;
        clear_log();
        send_addr(640);
        send_pixels(100);
        send_addr(960);
        send_pixels(320);
        drain();
        vectors++;
        if (n_short !== 1 || n_pkt !== 1 || n_bad !== 0) begin
            miscompares++;
            $display("FAIL short_pulses: got short=%0d pkt=%0d bad=%0d expected 1/1/0",
                     n_short, n_pkt, n_bad);
        end
        vectors++;
        if (q_addr.size() !== 420) begin
            miscompares++;
            $display("FAIL short_count: got %0d expected 420", q_addr.size());
        end else begin
            for (int i = 0; i < 420; i++) begin
                ea = (i < 100) ? 640 + i : 960 + (i - 100);
                ed = (i < 100) ? i : (i - 100) % 256;
                vectors++;
                if (q_addr[i] !== ea || q_data[i] !== ed) begin
                    miscompares++;
                    $display("FAIL short_beat[%0d]: got %0d/%0d expected %0d/%0d",
                             i, q_addr[i], q_data[i], ea, ed);
                end
            end
        end
    endtask

    task automatic test_stall_overflow();
        clear_log();
        wr_ready = 1'b0;
        send_addr(0);
        send_pixels(320);
        repeat (3) tick();
        vectors++;
        if (wr_valid !== 1'b1 || wr_addr !== 17'd0 || wr_data !== 8'd0) begin
            miscompares++;
            $display("FAIL stall_head: got v=%b addr=%0d data=%0d expected 1/0/0",
                     wr_valid, wr_addr, wr_data);
        end
        vectors++;
        if (ovf_count !== 16'd316 || n_pkt !== 1) begin
            miscompares++;
            $display("FAIL stall_ovf: got ovf=%0d pkt=%0d expected 316/1", ovf_count, n_pkt);
        end
        wr_ready = 1'b1;
        drain();
        vectors++;
        if (q_addr.size() !== 4 || wr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_drain: got beats=%0d v=%b expected 4/0", q_addr.size(), wr_valid);
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (q_addr[i] !== i || q_data[i] !== i) begin
                    miscompares++;
                    $display("FAIL stall_beat[%0d]: got %0d/%0d expected %0d/%0d",
                             i, q_addr[i], q_data[i], i, i);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        wr_ready = 1'b0;
        send_addr(0);
        send_pixels(50);
        vectors++;
        if (ovf_count !== 16'd362 || wr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_before: got ovf=%0d v=%b expected 362/1", ovf_count, wr_valid);
        end
        rst_n = 1'b0;
        tick();
        vectors++;
        if (wr_valid !== 1'b0 || ovf_count !== 16'd0 || wr_addr !== 17'd0) begin
            miscompares++;
            $display("FAIL midrst_after: got v=%b ovf=%0d addr=%0d expected 0/0/0",
                     wr_valid, ovf_count, wr_addr);
        end
        rst_n    = 1'b1;
        wr_ready = 1'b1;
        clear_log();
        send_pixels(20);
        drain();
        vectors++;
        if (q_addr.size() !== 0 || wr_valid !== 1'b0 || ovf_count !== 16'd0 || n_pkt !== 0) begin
            miscompares++;
            $display("FAIL midrst_ignore: got beats=%0d v=%b ovf=%0d pkt=%0d expected 0/0/0/0",
                     q_addr.size(), wr_valid, ovf_count, n_pkt);
        end
        clear_log();
        send_addr(320);
        send_pixels(320);
        drain();
        vectors++;
        if (q_addr.size() !== 320 || n_pkt !== 1) begin
            miscompares++;
            $display("FAIL midrst_resume: got beats=%0d pkt=%0d expected 320/1", q_addr.size(), n_pkt);
        end else begin
            vectors++;
            if (q_addr[0] !== 320 || q_addr[319] !== 639) begin
                miscompares++;
                $display("FAIL midrst_resume_addr: got %0d..%0d expected 320..639",
                         q_addr[0], q_addr[319]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_addr(1000);
        pixel_axiov = 1'b1;
        pixel       = 8'h11;
        tick();
        vectors++;
        if (wr_valid !== 1'b1 || wr_addr !== 17'd1000 || wr_data !== 8'h11) begin
            miscompares++;
            $display("FAIL latency: got v=%b addr=%0d data=%0h expected 1/1000/11",
                     wr_valid, wr_addr, wr_data);
        end
        // addr and pixel strobes together: the pixel must be ignored
        addr_axiov  = 1'b1;
        addr        = 24'd2000;
        pixel       = 8'hAA;
        tick();
        addr_axiov  = 1'b0;
        pixel_axiov = 1'b0;
        send_pixels(320);
        drain();
        vectors++;
        if (n_short !== 1 || n_pkt !== 1 || n_bad !== 0) begin
            miscompares++;
            $display("FAIL b2b_pulses: got short=%0d pkt=%0d bad=%0d expected 1/1/0",
                     n_short, n_pkt, n_bad);
        end
        vectors++;
        if (q_addr.size() !== 321) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d expected 321", q_addr.size());
        end else begin
            vectors++;
            if (q_addr[0] !== 1000 || q_data[0] !== 17 || q_addr[1] !== 2000 || q_data[1] !== 0
                || q_addr[320] !== 2319) begin
                miscompares++;
                $display("FAIL b2b_beats: got %0d/%0d %0d/%0d last=%0d expected 1000/17 2000/0 last=2319",
                         q_addr[0], q_data[0], q_addr[1], q_data[1], q_addr[320]);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        addr_axiov  = 1'b0;
        addr        = '0;
        pixel_axiov = 1'b0;
        pixel       = '0;
        wr_ready    = 1'b1;
        rst_n       = 1'b0;
        clear_log();
        test_reset();
        test_basic_packet();
        test_frame_end();
        test_bad_addr();
        test_short_packet();
        test_stall_overflow();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
